// File: rtl/adc_pkg.sv
// Shared definitions for the stonyman ADC link: responder FSM states and
// the default frame geometry used by both the capture controller and the responder.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int ADC_LEAD_ZEROS = 3;
  localparam int ADC_DATA_BITS  = 8;
  localparam int ADC_FRAME_BITS = 16;

endpackage

// File: rtl/adc_serial_responder_if.sv
// Serial link between the ADC capture controller (master) and the ADC or its
// responder model (slave): sclk/cs_n from the controller, sdata back.
interface adc_serial_responder_if;

  logic sclk;
  logic cs_n;
  logic sdata;
  logic sdata_oe;

  modport master (
    output sclk,
    output cs_n,
    input  sdata,
    input  sdata_oe
  );

  modport slave (
    input  sclk,
    input  cs_n,
    output sdata,
    output sdata_oe
  );

endinterface

// File: rtl/adc_serial_responder_edge_detect.sv
// Registers a synchronous level once and reports single-cycle rise/fall pulses
// relative to the previous sample.
module edge_detect #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic rise_o,
  output logic fall_o
);

  logic level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= RESET_LEVEL;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = ~level_q & level_i;
  assign fall_o = level_q & ~level_i;

endmodule

// File: rtl/adc_serial_responder.sv
// ADCxx1S101 serial responder: latches a sample on cs_n fall and shifts it out
// framed by leading/trailing zeros. Define ADC_RESP_RAMP_EN to send a ramp instead.
module adc_serial_responder
  import adc_pkg::*;
#(
  parameter int LEAD_ZEROS = ADC_LEAD_ZEROS,
  parameter int DATA_BITS  = ADC_DATA_BITS,
  parameter int FRAME_BITS = ADC_FRAME_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  adc_serial_responder_if.slave adc,
  input  logic [DATA_BITS-1:0] sample_data,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic [15:0]          conv_count
);

  localparam int BCW = $clog2(FRAME_BITS + 1);
  localparam logic [BCW-1:0] LZ_C       = BCW'(LEAD_ZEROS);
  localparam logic [BCW-1:0] DATA_END_C = BCW'(LEAD_ZEROS + DATA_BITS);
  localparam logic [BCW-1:0] FRAME_C    = BCW'(FRAME_BITS);

  logic fall_sclk;
  logic sclk_rise_unused;
  logic fall_cs;
  logic rise_cs;

  edge_detect #(.RESET_LEVEL(1'b1)) u_sclk_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (adc.sclk),
    .rise_o  (sclk_rise_unused),
    .fall_o  (fall_sclk)
  );

  edge_detect #(.RESET_LEVEL(1'b1)) u_cs_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (adc.cs_n),
    .rise_o  (rise_cs),
    .fall_o  (fall_cs)
  );

  state_t               state_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 sdata_q;
  logic                 sdata_oe_q;
  logic                 frame_done_q;
  logic                 frame_abort_q;
  logic [15:0]          conv_count_q;
  logic [BCW-1:0]       bit_next_d;
  logic                 in_data_d;
  logic [DATA_BITS-1:0] load_value_d;

`ifdef ADC_RESP_RAMP_EN
  logic [DATA_BITS-1:0] ramp_q;
  logic [DATA_BITS-1:0] sample_data_unused;

  assign sample_data_unused = sample_data;
  assign load_value_d       = ramp_q;

  // Only completed frames advance the ramp; aborts leave it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp_q <= '0;
    end else if (frame_done_q) begin
      ramp_q <= ramp_q + 1'b1;
    end
  end
`else
  assign load_value_d = sample_data;
`endif

  assign bit_next_d = bit_cnt_q + 1'b1;
  assign in_data_d  = (bit_next_d >= LZ_C) && (bit_next_d < DATA_END_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      sdata_q       <= 1'b0;
      sdata_oe_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      conv_count_q  <= '0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall_cs) begin
            shift_q    <= load_value_d;
            bit_cnt_q  <= '0;
            sdata_oe_q <= 1'b1;
            sdata_q    <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          // A cs_n rise beats a coincident sclk fall.
          if (rise_cs) begin
            sdata_oe_q    <= 1'b0;
            sdata_q       <= 1'b0;
            frame_abort_q <= 1'b1;
            state_q       <= IDLE;
          end else if (fall_sclk) begin
            bit_cnt_q <= bit_next_d;
            if (bit_next_d == FRAME_C) begin
              sdata_oe_q   <= 1'b0;
              sdata_q      <= 1'b0;
              frame_done_q <= 1'b1;
              conv_count_q <= conv_count_q + 16'd1;
              state_q      <= HOLD;
            end else if (in_data_d) begin
              // Data bits leave MSB first from the top of the shifter.
              sdata_q <= shift_q[DATA_BITS-1];
              shift_q <= shift_q << 1;
            end else begin
              sdata_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (rise_cs) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign adc.sdata    = sdata_q;
  assign adc.sdata_oe = sdata_oe_q;
  assign frame_done   = frame_done_q;
  assign frame_abort  = frame_abort_q;
  assign conv_count   = conv_count_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed plus randomized bench for adc_serial_responder; the expected serial
// stream is computed from the frame layout (leading zeros, data MSB first, trailing zeros).
module tb_adc_serial_responder;

  localparam int LZ = 3;
  localparam int DB = 8;
  localparam int FB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] sample_data;
  logic          frame_done;
  logic          frame_abort;
  logic [15:0]   conv_count;

  int checks = 0;
  int errors = 0;
  int cnt_m  = 0;
  int ramp_m = 0;

  adc_serial_responder_if bus ();

  adc_serial_responder #(
    .LEAD_ZEROS (LZ),
    .DATA_BITS  (DB),
    .FRAME_BITS (FB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .adc         (bus),
    .sample_data (sample_data),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .conv_count  (conv_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input int idx, input logic [DB-1:0] v);
    if (idx >= LZ && idx < LZ + DB) return v[DB-1-(idx-LZ)];
    return 1'b0;
  endfunction

  // One frame: abort_n < 0 runs to completion, otherwise cs_n rises after abort_n sclk falls.
  task automatic run_frame(input int fno, input logic [DB-1:0] v, input int abort_n,
                           input bit change_mid, input bit simul);
    logic [DB-1:0] exp_v;
`ifdef ADC_RESP_RAMP_EN
    exp_v = DB'(ramp_m);
`else
    exp_v = v;
`endif
    sample_data = v;
    bus.cs_n = 1'b0;
    tick();
    chk($sformatf("f%0d oe_start", fno), bus.sdata_oe, 1'b1);
    chk($sformatf("f%0d bit0", fno), bus.sdata, exp_bit(0, exp_v));
    if (change_mid) sample_data = v ^ DB'($urandom_range(1, 255));
    for (int k = 1; k <= FB; k++) begin
      if (k - 1 == abort_n) begin
        if (simul) bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        tick();
        chk($sformatf("f%0d abort_pulse", fno), frame_abort, 1'b1);
        chk($sformatf("f%0d abort_oe", fno), bus.sdata_oe, 1'b0);
        chk($sformatf("f%0d abort_sdata", fno), bus.sdata, 1'b0);
        chk($sformatf("f%0d abort_done", fno), frame_done, 1'b0);
        chk($sformatf("f%0d abort_count", fno), conv_count, 32'(cnt_m[15:0]));
        bus.sclk = 1'b1;
        tick();
        chk($sformatf("f%0d abort_once", fno), frame_abort, 1'b0);
        tick();
        return;
      end
      bus.sclk = 1'b0;
      tick();
      if (k < FB) begin
        chk($sformatf("f%0d bit%0d", fno, k), bus.sdata, exp_bit(k, exp_v));
        chk($sformatf("f%0d oe%0d", fno, k), bus.sdata_oe, 1'b1);
        chk($sformatf("f%0d done_early%0d", fno, k), frame_done, 1'b0);
      end else begin
        cnt_m  = (cnt_m + 1) % 65536;
        ramp_m = (ramp_m + 1) % 256;
        chk($sformatf("f%0d done", fno), frame_done, 1'b1);
        chk($sformatf("f%0d end_oe", fno), bus.sdata_oe, 1'b0);
        chk($sformatf("f%0d end_sdata", fno), bus.sdata, 1'b0);
        chk($sformatf("f%0d count", fno), conv_count, 32'(cnt_m[15:0]));
      end
      bus.sclk = 1'b1;
      tick();
      if (k == FB) chk($sformatf("f%0d done_once", fno), frame_done, 1'b0);
    end
    // Extra sclk activity while parked after the frame must not re-enable the pin.
    for (int k = 0; k < 2; k++) begin
      bus.sclk = 1'b0;
      tick();
      chk($sformatf("f%0d hold_oe%0d", fno, k), bus.sdata_oe, 1'b0);
      bus.sclk = 1'b1;
      tick();
    end
    bus.cs_n = 1'b1;
    tick();
    chk($sformatf("f%0d release_abort", fno), frame_abort, 1'b0);
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    bus.sclk    = 1'b1;
    bus.cs_n    = 1'b1;
    sample_data = '0;
    tick();
    tick();
    chk("rst_sdata", bus.sdata, 1'b0);
    chk("rst_oe", bus.sdata_oe, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_abort", frame_abort, 1'b0);
    chk("rst_count", conv_count, 32'h0);
    reset = 1'b0;
    tick();

    // sclk toggling while deselected is ignored.
    for (int k = 0; k < 3; k++) begin
      bus.sclk = 1'b0;
      tick();
      chk($sformatf("idle_oe%0d", k), bus.sdata_oe, 1'b0);
      bus.sclk = 1'b1;
      tick();
    end

    run_frame(1, 8'hA5, -1, 1'b0, 1'b0);
    run_frame(2, 8'hA5, -1, 1'b1, 1'b0);
    run_frame(3, 8'h5A, 6, 1'b0, 1'b0);
    run_frame(4, 8'hFF, -1, 1'b0, 1'b0);
    run_frame(5, 8'h81, 9, 1'b0, 1'b1);
    run_frame(6, 8'h00, -1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    sample_data = 8'hC3;
    bus.cs_n = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.sclk = 1'b0;
      tick();
      bus.sclk = 1'b1;
      tick();
    end
    chk("pre_rst_oe", bus.sdata_oe, 1'b1);
    #1;
    reset = 1'b1;
    bus.cs_n = 1'b1;
    #1;
    chk("async_rst_oe", bus.sdata_oe, 1'b0);
    chk("async_rst_sdata", bus.sdata, 1'b0);
    chk("async_rst_count", conv_count, 32'h0);
    cnt_m  = 0;
    ramp_m = 0;
    tick();
    reset = 1'b0;
    tick();
    bus.sclk = 1'b0;
    tick();
    chk("post_rst_idle_oe", bus.sdata_oe, 1'b0);
    bus.sclk = 1'b1;
    tick();

    for (int f = 0; f < 12; f++) begin
      logic [DB-1:0] v;
      int            an;
      v  = DB'($urandom_range(0, 255));
      an = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FB - 1)) : -1;
      run_frame(100 + f, v, an, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
